// File: rtl/sweep_iq_accumulator.sv
// ---------------------------------------------------------------------------
// sweep_iq_accumulator : per-point I/Q projection of NCH ADC channels onto a
// swept DDS reference, windowed on whole reference periods.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sweep_iq_accumulator #(
  parameter int NCH        = 2,
  parameter int ADC_WIDTH  = 14,
  parameter int REF_WIDTH  = 14,
  parameter int ACC_WIDTH  = 48,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                      clk125,
  input  logic                      areset_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ADDR_WIDTH-1:0]     num_points,
  input  logic [3:0]                num_cycles,
  input  logic [3:0]                settle_cycles,
  input  logic [REF_WIDTH-1:0]      ref_sin,
  input  logic [REF_WIDTH-1:0]      ref_cos,
  input  logic                      ref_zero,
  input  logic                      ref_valid,
  input  logic [NCH*ADC_WIDTH-1:0]  adc,
  output logic [ADDR_WIDTH-1:0]     freq_addr,
  output logic [NCH*ACC_WIDTH-1:0]  acc_i,
  output logic [NCH*ACC_WIDTH-1:0]  acc_q,
  output logic [23:0]               sample_count,
  output logic [ADDR_WIDTH-1:0]     res_point,
  output logic [NCH-1:0]            res_ovf,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int PW = ADC_WIDTH + REF_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_REF = 3'd1,
    S_SETTLE   = 3'd2,
    S_INTEG    = 3'd3,
    S_HOLD     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   freq_addr_q, freq_addr_d;
  logic [ADDR_WIDTH-1:0]   npts_q;
  logic [3:0]              ncyc_q;
  logic [3:0]              settle_q;
  logic                    v_q;
  logic                    flush_q;
  logic                    res_valid_q;
  logic [ADDR_WIDTH-1:0]   res_point_q;
  logic [23:0]             scnt_q;
  logic                    win_open;
  logic                    win_close;
  logic                    cfg_load;
  logic [PW-1:0]           sin_x;
  logic [PW-1:0]           cos_x;

  // Returns {overflow, saturated sum}; one guard bit is enough because the
  // accumulator is at least one bit wider than any product.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [PW-1:0]        p);
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {{(ACC_WIDTH+1-PW){p[PW-1]}}, p};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      sat_add = {1'b1, s[ACC_WIDTH], {(ACC_WIDTH-1){~s[ACC_WIDTH]}}};
    else
      sat_add = {1'b0, s[ACC_WIDTH-1:0]};
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    freq_addr_d = freq_addr_q;
    win_open    = 1'b0;
    win_close   = 1'b0;
    cfg_load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          freq_addr_d = '0;
          cfg_load    = 1'b1;
          state_d     = (num_points == '0) ? S_DONE : S_WAIT_REF;
        end
      end
      S_WAIT_REF: begin
        if (ref_valid) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (!ref_valid) begin
          state_d = S_WAIT_REF;
        end else if (ref_zero) begin
          if (cnt_q == settle_q) begin
            state_d  = S_INTEG;
            cnt_d    = '0;
            win_open = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_INTEG: begin
        if (!ref_valid) begin
          state_d = S_WAIT_REF;
        end else if (ref_zero) begin
          if (cnt_q + 4'd1 == ncyc_q) begin
            state_d   = S_HOLD;
            win_close = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_HOLD: begin
        if (res_valid_q && res_ready) begin
          if (freq_addr_q == npts_q - ADDR_ONE) begin
            state_d = S_DONE;
          end else begin
            freq_addr_d = freq_addr_q + ADDR_ONE;
            state_d     = S_SETTLE;
            cnt_d       = '0;
          end
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d     = S_IDLE;
      cnt_d       = cnt_q;
      freq_addr_d = freq_addr_q;
      win_open    = 1'b0;
      win_close   = 1'b0;
      cfg_load    = 1'b0;
    end
  end

  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      freq_addr_q <= '0;
      npts_q      <= '0;
      ncyc_q      <= 4'd1;
      settle_q    <= '0;
      v_q         <= 1'b0;
      flush_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_point_q <= '0;
      scnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      freq_addr_q <= freq_addr_d;
      // v_q marks the registered product as belonging to the window.
      v_q         <= win_open || (state_q == S_INTEG && state_d == S_INTEG);
      flush_q     <= win_close;
      if (cfg_load) begin
        npts_q   <= num_points;
        ncyc_q   <= (num_cycles == 4'd0) ? 4'd1 : num_cycles;
        settle_q <= settle_cycles;
      end
      if (abort) begin
        res_valid_q <= 1'b0;
      end else if (flush_q) begin
        res_valid_q <= 1'b1;
        res_point_q <= freq_addr_q;
      end else if (state_q == S_HOLD && res_valid_q && res_ready) begin
        res_valid_q <= 1'b0;
      end
      if (win_open)
        scnt_q <= '0;
      else if (v_q && scnt_q != 24'hFF_FFFF)
        scnt_q <= scnt_q + 24'd1;
    end
  end

  assign sin_x = {{ADC_WIDTH{ref_sin[REF_WIDTH-1]}}, ref_sin};
  assign cos_x = {{ADC_WIDTH{ref_cos[REF_WIDTH-1]}}, ref_cos};

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [PW-1:0]        adc_x;
      logic [PW-1:0]        prod_i_q;
      logic [PW-1:0]        prod_q_q;
      logic [ACC_WIDTH-1:0] acc_i_q;
      logic [ACC_WIDTH-1:0] acc_q_q;
      logic [ACC_WIDTH:0]   sum_i;
      logic [ACC_WIDTH:0]   sum_q;
      logic                 ovf_q;

      // Operands are pre-extended so the truncated PW-bit product is exact.
      assign adc_x = {{REF_WIDTH{adc[k*ADC_WIDTH+ADC_WIDTH-1]}},
                      adc[k*ADC_WIDTH +: ADC_WIDTH]};
      assign sum_i = sat_add(acc_i_q, prod_i_q);
      assign sum_q = sat_add(acc_q_q, prod_q_q);

      always_ff @(posedge clk125 or negedge areset_n) begin
        if (!areset_n) begin
          prod_i_q <= '0;
          prod_q_q <= '0;
          acc_i_q  <= '0;
          acc_q_q  <= '0;
          ovf_q    <= 1'b0;
        end else begin
          prod_i_q <= adc_x * sin_x;
          prod_q_q <= adc_x * cos_x;
          if (win_open) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
            ovf_q   <= 1'b0;
          end else if (v_q) begin
            acc_i_q <= sum_i[ACC_WIDTH-1:0];
            acc_q_q <= sum_q[ACC_WIDTH-1:0];
            ovf_q   <= ovf_q | sum_i[ACC_WIDTH] | sum_q[ACC_WIDTH];
          end
        end
      end

      assign acc_i[k*ACC_WIDTH +: ACC_WIDTH] = acc_i_q;
      assign acc_q[k*ACC_WIDTH +: ACC_WIDTH] = acc_q_q;
      assign res_ovf[k]                      = ovf_q;
    end
  endgenerate

  assign freq_addr    = freq_addr_q;
  assign sample_count = scnt_q;
  assign res_point    = res_point_q;
  assign res_valid    = res_valid_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done         = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_sweep_iq_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sweep_iq_accumulator : directed sweeps against square-wave references.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sweep_iq_accumulator;

  localparam int AW = 48;
  localparam int SW = 29;
  // 8191^2 = 67092481; window sums below are N * that.
  localparam logic [47:0] E100  = 48'd6709248100;
  localparam logic [47:0] E200  = 48'd13418496200;
  localparam logic [47:0] E1500 = 48'd100638721500;
  localparam logic [47:0] E100N = 48'd0 - 48'd6709248100;
  localparam logic [28:0] SMAX  = 29'd268435455;

  logic clk125 = 1'b0;
  logic areset_n, start, abort, ref_zero, ref_valid, res_ready;
  logic [7:0] num_points;
  logic [3:0] num_cycles, settle_cycles;
  logic signed [13:0] ref_sin, ref_cos;
  logic [27:0] adc;

  logic [7:0]      freq_addr, res_point, s_freq_addr, s_res_point;
  logic [2*AW-1:0] acc_i, acc_q;
  logic [2*SW-1:0] s_acc_i, s_acc_q;
  logic [23:0]     sample_count, s_sample_count;
  logic [1:0]      res_ovf, s_res_ovf;
  logic            res_valid, busy, done, s_res_valid, s_busy, s_done;

  int n_checks = 0;
  int n_errors = 0;
  int phase = 0, cyc = 0, zero_cyc = 0;
  int ref_mode = 0, adc_mode = 0;
  int bad;

  sweep_iq_accumulator u_dut (
    .clk125(clk125), .areset_n(areset_n), .start(start), .abort(abort),
    .num_points(num_points), .num_cycles(num_cycles), .settle_cycles(settle_cycles),
    .ref_sin(ref_sin), .ref_cos(ref_cos), .ref_zero(ref_zero), .ref_valid(ref_valid),
    .adc(adc), .freq_addr(freq_addr), .acc_i(acc_i), .acc_q(acc_q),
    .sample_count(sample_count), .res_point(res_point), .res_ovf(res_ovf),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .done(done)
  );

  sweep_iq_accumulator #(.ACC_WIDTH(SW)) u_sat (
    .clk125(clk125), .areset_n(areset_n), .start(start), .abort(abort),
    .num_points(num_points), .num_cycles(num_cycles), .settle_cycles(settle_cycles),
    .ref_sin(ref_sin), .ref_cos(ref_cos), .ref_zero(ref_zero), .ref_valid(ref_valid),
    .adc(adc), .freq_addr(s_freq_addr), .acc_i(s_acc_i), .acc_q(s_acc_q),
    .sample_count(s_sample_count), .res_point(s_res_point), .res_ovf(s_res_ovf),
    .res_valid(s_res_valid), .res_ready(res_ready), .busy(s_busy), .done(s_done)
  );

  always #5 clk125 = ~clk125;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Square-wave references, period 100, ref_zero on the rising edge of sin.
  task automatic set_ref();
    logic signed [13:0] s, c;
    if (ref_mode == 0) begin
      s = (phase < 50) ? 14'sd8191 : -14'sd8191;
      c = (phase < 25 || phase >= 75) ? 14'sd8191 : -14'sd8191;
    end else begin
      s = 14'sd8191;
      c = 14'sd8191;
    end
    ref_sin  = s;
    ref_cos  = c;
    ref_zero = (phase == 0);
    case (adc_mode)
      0:       adc = {c, s};
      1:       adc = {s, -s};
      default: adc = {14'sd8191, 14'sd8191};
    endcase
  endtask

  task automatic wait_res(input int budget, input string tag);
    int n = 0;
    while (res_valid !== 1'b1 && n < budget) begin
      @(negedge clk125);
      n++;
    end
    check({tag, "_valid"}, 64'(res_valid), 64'd1);
  endtask

  initial begin
    set_ref();
    forever begin
      @(posedge clk125);
      #1;
      cyc++;
      phase = (phase == 99) ? 0 : phase + 1;
      set_ref();
      if (ref_zero) zero_cyc = cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    areset_n = 1'b0; start = 1'b0; abort = 1'b0; ref_valid = 1'b1; res_ready = 1'b1;
    num_points = 8'd0; num_cycles = 4'd0; settle_cycles = 4'd0;
    repeat (2) @(negedge clk125);
    check("rst_flags", 64'({res_valid, busy, done, res_ovf}), 64'd0);
    check("rst_data", 64'((|acc_i) | (|acc_q) | (|sample_count) | (|res_point) | (|freq_addr)), 64'd0);
    areset_n = 1'b1;
    @(negedge clk125);

    // Three points, 2 periods each, one settle period.
    num_points = 8'd3; num_cycles = 4'd2; settle_cycles = 4'd1; start = 1'b1;
    for (int p = 0; p < 3; p++) begin
      wait_res(1000, "t1");
      check("t1_latency", 64'(cyc - zero_cyc), 64'd2);
      check("t1_point", 64'(res_point), 64'(p));
      check("t1_count", 64'(sample_count), 64'd200);
      check("t1_i0", 64'(acc_i[47:0]), 64'(E200));
      check("t1_q0", 64'(acc_q[47:0]), 64'd0);
      check("t1_i1", 64'(acc_i[95:48]), 64'd0);
      check("t1_q1", 64'(acc_q[95:48]), 64'(E200));
      check("t1_ovf", 64'(res_ovf), 64'd0);
      @(negedge clk125);
      check("t1_rv_drop", 64'(res_valid), 64'd0);
    end
    check("t1_done", 64'(done), 64'd1);
    check("t1_busy", 64'(busy), 64'd0);
    start = 1'b0;
    @(negedge clk125);
    check("t1_done_clr", 64'(done), 64'd0);

    // Backpressure, num_cycles=0 as 1, mid-sweep config changes ignored.
    adc_mode = 1; num_points = 8'd2; num_cycles = 4'd0; settle_cycles = 4'd0;
    res_ready = 1'b0; start = 1'b1;
    @(negedge clk125);
    start = 1'b0; num_points = 8'd1; num_cycles = 4'd5;
    check("t2_busy", 64'(busy), 64'd1);
    wait_res(500, "t2");
    check("t2_count", 64'(sample_count), 64'd100);
    check("t2_i0", 64'(acc_i[47:0]), 64'(E100N));
    check("t2_i1", 64'(acc_i[95:48]), 64'(E100));
    check("t2_q0", 64'(acc_q[47:0]), 64'd0);
    check("t2_q1", 64'(acc_q[95:48]), 64'd0);
    bad = 0;
    repeat (50) begin
      @(negedge clk125);
      if (res_valid !== 1'b1 || acc_i[47:0] !== E100N || acc_i[95:48] !== E100 ||
          sample_count !== 24'd100 || freq_addr !== 8'd0 || res_point !== 8'd0) bad++;
    end
    check("t2_hold_stable", 64'(bad), 64'd0);
    res_ready = 1'b1;
    @(negedge clk125);
    check("t2_rv_drop", 64'(res_valid), 64'd0);
    check("t2_addr_inc", 64'(freq_addr), 64'd1);
    wait_res(500, "t2b");
    check("t2b_point", 64'(res_point), 64'd1);
    check("t2b_count", 64'(sample_count), 64'd100);
    @(negedge clk125);
    check("t2_done", 64'(done), 64'd1);
    @(negedge clk125);
    check("t2_done_clr", 64'(done), 64'd0);

    // Full-scale inputs over 15 periods: 29-bit instance must saturate.
    ref_mode = 1; adc_mode = 2; num_points = 8'd1; num_cycles = 4'd15; settle_cycles = 4'd0;
    start = 1'b1;
    @(negedge clk125);
    start = 1'b0;
    wait_res(2000, "t3");
    check("t3_i0_wide", 64'(acc_i[47:0]), 64'(E1500));
    check("t3_q1_wide", 64'(acc_q[95:48]), 64'(E1500));
    check("t3_ovf_wide", 64'(res_ovf), 64'd0);
    check("t3_sat_valid", 64'(s_res_valid), 64'd1);
    check("t3_sat_i0", 64'(s_acc_i[28:0]), 64'(SMAX));
    check("t3_sat_q1", 64'(s_acc_q[57:29]), 64'(SMAX));
    check("t3_sat_ovf", 64'(s_res_ovf), 64'd3);
    check("t3_sat_count", 64'(s_sample_count), 64'd1500);
    repeat (2) @(negedge clk125);
    ref_mode = 0; adc_mode = 0;

    // Abort mid-integration of point 1.
    num_points = 8'd3; num_cycles = 4'd2; settle_cycles = 4'd1; start = 1'b1;
    @(negedge clk125);
    start = 1'b0;
    wait_res(1000, "t4");
    check("t4_point", 64'(res_point), 64'd0);
    @(negedge clk125);
    repeat (300) @(negedge clk125);
    check("t4_busy_pre", 64'(busy), 64'd1);
    check("t4_addr_pre", 64'(freq_addr), 64'd1);
    abort = 1'b1;
    @(negedge clk125);
    abort = 1'b0;
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_flags", 64'({res_valid, done}), 64'd0);
    check("t4_addr_held", 64'(freq_addr), 64'd1);
    bad = 0;
    repeat (500) begin
      @(negedge clk125);
      if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("t4_quiet", 64'(bad), 64'd0);
    start = 1'b1;
    @(negedge clk125);
    start = 1'b0;
    check("t4_restart_addr", 64'(freq_addr), 64'd0);
    check("t4_restart_busy", 64'(busy), 64'd1);

    // Asynchronous reset while holding a result.
    res_ready = 1'b0;
    wait_res(1000, "t5");
    check("t5_point", 64'(res_point), 64'd0);
    check("t5_i0", 64'(acc_i[47:0]), 64'(E200));
    #2 areset_n = 1'b0;
    #1;
    check("t5_rst_flags", 64'({res_valid, busy, done, res_ovf}), 64'd0);
    check("t5_rst_acc", 64'((|acc_i) | (|acc_q)), 64'd0);
    check("t5_rst_count", 64'(sample_count), 64'd0);
    check("t5_rst_addr", 64'({freq_addr, res_point}), 64'd0);
    @(negedge clk125);
    areset_n = 1'b1; res_ready = 1'b1;
    bad = 0;
    repeat (300) begin
      @(negedge clk125);
      if (res_valid !== 1'b0) bad++;
    end
    check("t5_no_result", 64'(bad), 64'd0);

    // Zero-point sweep goes straight to DONE.
    num_points = 8'd0; start = 1'b1;
    @(negedge clk125);
    check("t6_done", 64'(done), 64'd1);
    check("t6_busy_rv", 64'({busy, res_valid}), 64'd0);
    start = 1'b0;
    @(negedge clk125);
    check("t6_done_clr", 64'(done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sweep_iq_accumulator.md
SWEEP_IQ_ACCUMULATOR -- requirements
Module: sweep_iq_accumulator

Interface
REQ-001 Parameter NCH, default 2: number of ADC channels projected in parallel.
REQ-002 Parameter ADC_WIDTH, default 14: signed ADC sample width.
REQ-003 Parameter REF_WIDTH, default 14: signed DDS sin/cos reference width.
REQ-004 Parameter ACC_WIDTH, default 48: signed accumulator width, SHALL be >= ADC_WIDTH+REF_WIDTH+1.
REQ-005 Parameter ADDR_WIDTH, default 8: sweep point index width.
REQ-006 clk125  in  1  sole clock; all logic on its rising edge.
REQ-007 areset_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  level; high in IDLE begins a sweep.
REQ-009 abort  in  1  synchronous sweep cancel.
REQ-010 num_points  in  ADDR_WIDTH  sweep points to measure.
REQ-011 num_cycles  in  4  reference periods integrated per point (0 treated as 1).
REQ-012 settle_cycles  in  4  reference periods discarded after each retune.
REQ-013 ref_sin, ref_cos  in  REF_WIDTH each  signed DDS outputs.
REQ-014 ref_zero  in  1  one-cycle pulse at rising zero crossing of ref_sin.
REQ-015 ref_valid  in  1  DDS output valid.
REQ-016 adc  in  NCH*ADC_WIDTH  signed samples, channel k at bits [k*ADC_WIDTH +: ADC_WIDTH].
REQ-017 freq_addr  out  ADDR_WIDTH  current point index, drives frequency-increment ROM.
REQ-018 acc_i, acc_q  out  NCH*ACC_WIDTH each  per-channel in-phase (x sin) and quadrature (x cos) sums.
REQ-019 sample_count  out  24  samples integrated in the presented result.
REQ-020 res_point  out  ADDR_WIDTH  index of presented result.
REQ-021 res_ovf  out  NCH  per-channel sticky saturation flag for the presented result.
REQ-022 res_valid  out  1 / res_ready  in  1  result handshake; transfer when both high.
REQ-023 busy  out  1 / done  out  1  sweep active / sweep complete.

Function
REQ-024 FSM states: IDLE, WAIT_REF, SETTLE, INTEG, HOLD, DONE.
REQ-025 IDLE: start=1 -> freq_addr<=0; if num_points=0 -> DONE, else -> WAIT_REF.
REQ-026 WAIT_REF: ref_valid=1 -> SETTLE, settle counter cleared.
REQ-027 SETTLE: each ref_zero increments settle counter; ref_zero with counter = settle_cycles -> INTEG, that ref_zero opens the window.
REQ-028 Window: samples from the opening ref_zero cycle (inclusive) to the closing ref_zero (exclusive), closing = max(num_cycles,1)-th ref_zero after opening.
REQ-029 Products adc_k*ref_sin and adc_k*ref_cos SHALL be registered once (full ADC_WIDTH+REF_WIDTH signed), then sign-extended and added into the ACC_WIDTH accumulators.
REQ-030 Accumulator add overflow SHALL saturate to the signed max/min and set the channel's sticky ovf bit; bits clear at window open.
REQ-031 Accumulators and sample counter clear on the opening cycle; sample counter saturates at 2^24-1.
REQ-032 Closing ref_zero -> HOLD; res_valid, acc_i/q, sample_count, res_ovf, res_point=freq_addr valid exactly 2 cycles after the closing ref_zero, after pipeline flush.
REQ-033 HOLD: outputs stable while res_valid=1 and res_ready=0; no accumulation.
REQ-034 HOLD transfer: if freq_addr = num_points-1 -> DONE, else freq_addr+1 and -> SETTLE (counter cleared).
REQ-035 res_valid deasserts the cycle after transfer.
REQ-036 DONE: done=1; start=0 -> IDLE with done<=0.
REQ-037 busy=1 in every state except IDLE and DONE.
REQ-038 abort=1 in any state -> IDLE next cycle; res_valid, busy, done <=0; freq_addr held; abort has priority over all other events.
REQ-039 ref_valid=0 during SETTLE or INTEG -> WAIT_REF; partial sums discarded, point not advanced.
REQ-040 ref_zero coincident with state entry to SETTLE counts toward settle.
REQ-041 num_points, num_cycles, settle_cycles sampled at sweep start; changes mid-sweep ignored.

Reset
REQ-042 areset_n=0 -> IDLE; freq_addr, acc_i, acc_q, sample_count, res_point, res_ovf, res_valid, busy, done all 0, independent of clock.
REQ-043 Reset mid-sweep discards all partial results; no res_valid until a new start.

Verification
REQ-044 NCH=2, ref period 100 cycles, num_points=3, num_cycles=2, settle_cycles=1, res_ready=1 -> 3 results, res_point 0,1,2, sample_count=200 each, done=1 after third.
REQ-045 adc ch0=ref_sin, ch1=ref_cos (amplitude 8191) -> acc_q ch0 ~0 and acc_i ch0 ~+sum(sin^2); ch1 reversed; within 1 LSB per sample of model.
REQ-046 res_ready held low 50 cycles in HOLD -> outputs constant, no freq_addr change, transfer on release, freq_addr+1 next cycle.
REQ-047 ACC_WIDTH=29, adc and refs at full positive scale, num_cycles=15 -> acc_i saturates at 2^28-1, res_ovf=1 for that channel.
REQ-048 abort asserted mid-INTEG of point 1 -> IDLE next cycle, busy=0, no res_valid; new start restarts at freq_addr=0.
REQ-049 areset_n pulsed low in HOLD -> all outputs 0 immediately; num_points=0 start -> DONE with zero results.
